// File: rtl/twiddle_addr_seq_if.sv
// Sample/twiddle bus of the twiddle address sequencer: input samples, twiddle number, delayed samples.
// Optional TWADDR_TRIVIAL_FLAG_EN adds the tw_trivial bypass flag.
interface twiddle_addr_seq_if #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
);
    logic             clear;
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic [LOG_N-1:0] tw_addr;
    logic             tw_valid;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;
`ifdef TWADDR_TRIVIAL_FLAG_EN
    logic             tw_trivial;
`endif

    // Master is the upstream sample source; slave is the sequencer.
    modport master (
        output clear, di_en, di_re, di_im,
        input  tw_addr, tw_valid, do_en, do_re, do_im, do_last
`ifdef TWADDR_TRIVIAL_FLAG_EN
        , input tw_trivial
`endif
    );

    modport slave (
        input  clear, di_en, di_re, di_im,
        output tw_addr, tw_valid, do_en, do_re, do_im, do_last
`ifdef TWADDR_TRIVIAL_FLAG_EN
        , output tw_trivial
`endif
    );
endinterface

// File: rtl/twiddle_addr_seq.sv
// Twiddle address sequencer for one R2^2 SDF stage: indexes samples in an N-point frame, emits the
// twiddle number one cycle later, and delays data by 1+DELAY cycles. Optional macro: TWADDR_TRIVIAL_FLAG_EN.
module twiddle_addr_seq #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16,
    parameter int DELAY = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    twiddle_addr_seq_if.slave  bus
);

    logic [LOG_N-1:0] cnt;
    logic [LOG_N-1:0] idx;
    logic [1:0]       sel;
    logic [LOG_N-3:0] num;
    logic [LOG_N-1:0] prod;
    logic             last_in;
    logic             trivial_in;

    logic [LOG_N-1:0] tw_addr_q;
    logic             tw_valid_q;

    logic [DELAY:0]   en_pipe;
    logic [DELAY:0]   last_pipe;
    logic [WIDTH-1:0] re_pipe [DELAY+1];
    logic [WIDTH-1:0] im_pipe [DELAY+1];
`ifdef TWADDR_TRIVIAL_FLAG_EN
    logic [DELAY:0]   triv_pipe;
`endif

    // clear forces the current sample to index 0 in the same cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx        = bus.clear ? '0 : cnt;
        sel        = {idx[LOG_N-2], idx[LOG_N-1]};
        num        = idx[LOG_N-3:0];
        prod       = LOG_N'(sel) * LOG_N'(num);
        last_in    = bus.di_en && (idx == {LOG_N{1'b1}});
        trivial_in = bus.di_en && ((sel == 2'd0) || (num == '0));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            tw_addr_q  <= '0;
            tw_valid_q <= 1'b0;
        end else begin
            if (bus.di_en) begin
                cnt       <= idx + LOG_N'(1);
                tw_addr_q <= prod;
            end else if (bus.clear) begin
                cnt <= '0;
            end
            tw_valid_q <= bus.di_en;
        end
    end

    // Free-running delay line: loads every cycle, never stalls, not flushed by clear.
    // NOTE: the data stages are register arrays, yet they are reset too so no stale sample survives reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_pipe   <= '0;
            last_pipe <= '0;
            for (int i = 0; i <= DELAY; i++) begin
                re_pipe[i] <= '0;
                im_pipe[i] <= '0;
            end
        end else begin
            en_pipe[0]   <= bus.di_en;
            last_pipe[0] <= last_in;
            re_pipe[0]   <= bus.di_re;
            im_pipe[0]   <= bus.di_im;
            for (int i = 1; i <= DELAY; i++) begin
                en_pipe[i]   <= en_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                re_pipe[i]   <= re_pipe[i-1];
                im_pipe[i]   <= im_pipe[i-1];
            end
        end
    end

`ifdef TWADDR_TRIVIAL_FLAG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            triv_pipe <= '0;
        end else begin
            triv_pipe[0] <= trivial_in;
            for (int i = 1; i <= DELAY; i++) begin
                triv_pipe[i] <= triv_pipe[i-1];
            end
        end
    end

    assign bus.tw_trivial = triv_pipe[DELAY];
`endif

    assign bus.tw_addr  = tw_addr_q;
    assign bus.tw_valid = tw_valid_q;
    assign bus.do_en    = en_pipe[DELAY];
    assign bus.do_last  = last_pipe[DELAY];
    assign bus.do_re    = re_pipe[DELAY];
    assign bus.do_im    = im_pipe[DELAY];

endmodule
